// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART RX FIFO. Hunts for 55 AA LEN CMD payload CSUM frames, checks
// them and replays the payload on a valid/ready stream. Optional idle abort: FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  output logic       rd_en,
  input  logic [7:0] din,
  input  logic       empty,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] out_cmd,
  output logic [7:0] out_len,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    StHunt1,
    StHunt2,
    StLen,
    StCmd,
    StPayload,
    StCsum,
    StEmit
  } state_e;

  state_e            state_q, state_d;
  logic              rd_pend_q;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        sum_q, sum_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [7:0]        out_cmd_q, out_cmd_d;
  logic [7:0]        out_len_q, out_len_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [7:0]        pay_mem [MAX_LEN];
  logic              mem_we;
  logic              consume;
  logic              reject;
  logic              timeout;
  logic [IdxW-1:0]   idx_inc;
  logic [7:0]        idx_ext;
  logic [7:0]        len_m1;

  assign consume = rd_pend_q;
  assign idx_inc = idx_q + IdxW'(1);
  assign idx_ext = 8'(idx_q);
  assign len_m1  = len_q - 8'd1;

  // At most one byte in flight; nothing is popped while replaying a frame.
  assign rd_en = !rst && !empty && !rd_pend_q && (state_q != StEmit);

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             timed;

  assign timed = (state_q != StHunt1) && (state_q != StEmit);

  always_comb begin
    idle_d  = '0;
    timeout = 1'b0;
    if (timed && !consume) begin
      if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cmd_d       = cmd_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_cmd_d   = out_cmd_q;
    out_len_d   = out_len_q;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    mem_we      = 1'b0;
    reject      = 1'b0;

    unique case (state_q)
      StHunt1: begin
        if (consume && din == 8'h55) state_d = StHunt2;
      end
      StHunt2: begin
        if (consume) begin
          if (din == 8'hAA)      state_d = StLen;
          else if (din == 8'h55) state_d = StHunt2;
          else                   state_d = StHunt1;
        end
      end
      StLen: begin
        if (consume) begin
          if (din == 8'd0 || din > MaxLenB) begin
            reject = 1'b1;
          end else begin
            len_d   = din;
            sum_d   = din;
            idx_d   = '0;
            state_d = StCmd;
          end
        end
      end
      StCmd: begin
        if (consume) begin
          cmd_d   = din;
          sum_d   = sum_q + din;
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (consume) begin
          mem_we = 1'b1;
          sum_d  = sum_q + din;
          idx_d  = idx_inc;
          if (idx_ext == len_m1) state_d = StCsum;
        end
      end
      StCsum: begin
        if (consume) begin
          if (din == sum_q) begin
            state_d     = StEmit;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = pay_mem[0];
            out_last_d  = (len_q == 8'd1);
            out_cmd_d   = cmd_q;
            out_len_d   = len_q;
          end else begin
            reject = 1'b1;
          end
        end
      end
      StEmit: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = StHunt1;
          end else begin
            idx_d      = idx_inc;
            out_data_d = pay_mem[idx_inc];
            out_last_d = ((idx_ext + 8'd1) == len_m1);
          end
        end
      end
      default: state_d = StHunt1;
    endcase

    if (timeout) reject = 1'b1;

    // The offending byte is dropped, not re-examined as a header.
    if (reject) begin
      state_d     = StHunt1;
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q     <= StHunt1;
      rd_pend_q   <= 1'b0;
      len_q       <= '0;
      cmd_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_cmd_q   <= '0;
      out_len_q   <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_en;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_cmd_q   <= out_cmd_d;
      out_len_q   <= out_len_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (mem_we) pay_mem[idx_q] <= din;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_cmd   = out_cmd_q;
  assign out_len   = out_len_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
